// File: rtl/fsm_chk_pkg.sv
// Shared types and default constants for the sequence checker slice.
// Build option: define FSM_CHK_WRAPCNT_EN to include the completed-period counter.
package fsm_chk_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } chk_state_e;

    localparam int DEF_WIDTH       = 5;
    localparam int DEF_MAX_COUNT   = 12;
    localparam int DEF_LOCK_CYCLES = 2;
    localparam int DEF_ERR_LIMIT   = 3;

    localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
module sat_counter
    import fsm_chk_pkg::*;
#(
    parameter int W = CNT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fsm_seq_checker.sv
// Lock/flywheel checker for the 0..MAX_COUNT free-running count bus.
// Build option: FSM_CHK_WRAPCNT_EN builds the wrap_cnt register; otherwise wrap_cnt is tied to 0.
module fsm_seq_checker
    import fsm_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX_COUNT   = DEF_MAX_COUNT,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int ERR_LIMIT   = DEF_ERR_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     In_1,
    input  logic                 in_valid,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] wrap_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    localparam int LC_W = $clog2(LOCK_CYCLES + 1);
    localparam int EL_W = $clog2(ERR_LIMIT + 1);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    localparam logic [LC_W-1:0]  LOCK_TGT = LC_W'(LOCK_CYCLES);
    localparam logic [EL_W-1:0]  ERR_TGT  = EL_W'(ERR_LIMIT);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [LC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [EL_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic             locked_q;
    logic             err_q, err_d;

    logic [WIDTH-1:0] next_exp;
    logic             sample_match;

    // expected never exceeds MAX_COUNT, so out-of-range samples can never match
    assign next_exp     = (expected_q == MAX_VAL) ? '0 : expected_q + 1'b1;
    assign sample_match = (In_1 == expected_q);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (In_1 == '0) begin
                        match_cnt_d = LC_W'(1);
                        expected_d  = WIDTH'(1);
                        state_d     = (LOCK_CYCLES == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (sample_match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        expected_d  = next_exp;
                        if (match_cnt_q + 1'b1 == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else if (In_1 == '0) begin
                        match_cnt_d = LC_W'(1);
                        expected_d  = WIDTH'(1);
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // flywheel: keep counting through glitches
                    expected_d = next_exp;
                    if (sample_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_cnt_q + 1'b1 == ERR_TGT) begin
                            state_d     = HUNT;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= (state_d == LOCKED);
            err_q       <= err_d;
        end
    end

    assign locked = locked_q;
    assign err    = err_q;

    sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (err_d),
        .count (err_cnt)
    );

`ifdef FSM_CHK_WRAPCNT_EN
    logic wrap_inc;

    assign wrap_inc = in_valid && (state_q == LOCKED) && sample_match && (In_1 == MAX_VAL);

    sat_counter #(.W(CNT_WIDTH)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (wrap_inc),
        .count (wrap_cnt)
    );
`else
    assign wrap_cnt = '0;
`endif

endmodule
